// File: rtl/shift_mac_ctrl.sv
// Shift-and-add MAC controller driving two external shift registers; accumulates dot-product frames.
// Optional macro SHIFT_MAC_EARLY_EXIT_EN: end RUN early once the multiplier register is all zero.
module shift_mac_ctrl #(
    parameter int N     = 8,
    parameter int ACC_W = 2*N
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N-1:0]     in_a,
    input  logic [N-1:0]     in_b,
    input  logic             in_last,
    output logic             sr_load,
    output logic             sr_clear,
    output logic             sr_shift,
    output logic [2*N-1:0]   sr_a_in,
    output logic [N-1:0]     sr_b_in,
    input  logic [2*N-1:0]   a_q,
    input  logic             b_lsb,
    input  logic             b_zero,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_acc,
    output logic             out_ovf,
    output logic             busy
);
    localparam int CNT_W = (N > 2) ? $clog2(N) : 1;

    typedef enum logic [1:0] {IDLE, RUN, OUT} state_t;

    state_t             r_state, w_state_next;
    logic [CNT_W-1:0]   r_cnt;
    logic [ACC_W-1:0]   r_acc;
    logic               r_ovf;
    logic               r_last;

    logic               w_load, w_shift, w_clear, w_add, w_done, w_early;
    logic [ACC_W:0]     w_sum;

`ifdef SHIFT_MAC_EARLY_EXIT_EN
    assign w_early = b_zero;
`else
    localparam bit EARLY_EN = 1'b0;
    assign w_early = EARLY_EN & b_zero;
`endif

    // Extra top bit catches the carry out of the accumulator for the sticky overflow flag.
    assign w_sum = {1'b0, r_acc} + (ACC_W+1)'(a_q);

    always_comb begin
        w_state_next = r_state;
        in_ready     = 1'b0;
        out_valid    = 1'b0;
        w_load       = 1'b0;
        w_shift      = 1'b0;
        w_clear      = 1'b0;
        w_add        = 1'b0;
        w_done       = 1'b0;
        case (r_state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_load       = 1'b1;
                    w_state_next = RUN;
                end
            end
            RUN: begin
                if (w_early) begin
                    w_done = 1'b1;
                end else begin
                    w_shift = 1'b1;
                    w_add   = b_lsb;
                    w_done  = (r_cnt == CNT_W'(N-1));
                end
                if (w_done)
                    w_state_next = r_last ? OUT : IDLE;
            end
            OUT: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    w_clear      = 1'b1;
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    // Strobes are gated by reset so the external registers see nothing while reset is held.
    assign sr_load  = w_load  & reset_n;
    assign sr_shift = w_shift & reset_n;
    assign sr_clear = w_clear & reset_n;
    assign sr_a_in  = {{N{1'b0}}, in_a};
    assign sr_b_in  = in_b;
    assign out_acc  = r_acc;
    assign out_ovf  = r_ovf;
    assign busy     = (r_state != IDLE);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            r_state <= IDLE;
        else
            r_state <= w_state_next;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt  <= '0;
            r_acc  <= '0;
            r_ovf  <= 1'b0;
            r_last <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_last <= in_last;
                        r_cnt  <= '0;
                    end
                end
                RUN: begin
                    r_cnt <= r_cnt + CNT_W'(1);
                    if (w_add) begin
                        r_acc <= w_sum[ACC_W-1:0];
                        r_ovf <= r_ovf | w_sum[ACC_W];
                    end
                end
                OUT: begin
                    if (out_ready) begin
                        r_acc <= '0;
                        r_ovf <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_shift_mac_ctrl.sv
// Directed bench for shift_mac_ctrl; models the two external shift registers around the DUT.
module tb_shift_mac_ctrl;
    localparam int N     = 8;
    localparam int ACC_W = 16;
`ifdef SHIFT_MAC_EARLY_EXIT_EN
    localparam int RC_B0 = 1;
    localparam int RC_B1 = 2;
`else
    localparam int RC_B0 = 8;
    localparam int RC_B1 = 8;
`endif

    logic             clk = 1'b0;
    logic             reset_n;
    logic             in_valid, in_ready, in_last;
    logic [N-1:0]     in_a, in_b;
    logic             sr_load, sr_clear, sr_shift;
    logic [2*N-1:0]   sr_a_in;
    logic [N-1:0]     sr_b_in;
    logic [2*N-1:0]   a_reg;
    logic [N-1:0]     b_reg;
    logic             out_valid, out_ready, out_ovf, busy;
    logic [ACC_W-1:0] out_acc;

    int n_checks = 0;
    int n_err    = 0;
    int rc;

    always #5 clk = ~clk;

    shift_mac_ctrl #(.N(N), .ACC_W(ACC_W)) dut (
        .clk(clk), .reset_n(reset_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b), .in_last(in_last),
        .sr_load(sr_load), .sr_clear(sr_clear), .sr_shift(sr_shift),
        .sr_a_in(sr_a_in), .sr_b_in(sr_b_in),
        .a_q(a_reg), .b_lsb(b_reg[0]), .b_zero(b_reg == '0),
        .out_valid(out_valid), .out_ready(out_ready), .out_acc(out_acc), .out_ovf(out_ovf),
        .busy(busy)
    );

    // External shift registers: A shifts left, B shifts right.
    always @(posedge clk) begin
        if (sr_clear) begin
            a_reg <= '0;
            b_reg <= '0;
        end else if (sr_load) begin
            a_reg <= sr_a_in;
            b_reg <= sr_b_in;
        end else if (sr_shift) begin
            a_reg <= a_reg << 1;
            b_reg <= b_reg >> 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Called at a falling edge; returns at a falling edge once RUN has ended.
    task automatic do_op(input logic [N-1:0] a, input logic [N-1:0] b, input logic last,
                         output int cycles);
        in_a = a; in_b = b; in_last = last; in_valid = 1'b1;
        #1;
        check("accept_ready", in_ready, 1);
        check("accept_load", sr_load, 1);
        @(posedge clk); @(negedge clk);
        in_valid = 1'b0;
        cycles = 0;
        while (busy && !out_valid && cycles < 40) begin
            cycles++;
            @(negedge clk);
        end
        $display("op a=%0d b=%0d last=%0d run_cycles=%0d", a, b, last, cycles);
    endtask

    task automatic out_hs(input string tag, input logic [31:0] exp_acc, input logic exp_ovf);
        check({tag, "_valid"}, out_valid, 1);
        check({tag, "_acc"}, out_acc, exp_acc);
        check({tag, "_ovf"}, out_ovf, exp_ovf);
        $display("out %s acc=%0d ovf=%0d", tag, out_acc, out_ovf);
        out_ready = 1'b1;
        #1;
        check({tag, "_clear"}, sr_clear, 1);
        @(posedge clk); @(negedge clk);
        out_ready = 1'b0;
        #1;
        check({tag, "_idle_valid"}, out_valid, 0);
        check({tag, "_idle_clear"}, sr_clear, 0);
        check({tag, "_idle_ready"}, in_ready, 1);
    endtask

    initial begin
        reset_n = 1'b0; in_valid = 1'b1; in_a = 8'd1; in_b = 8'd1; in_last = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_load", sr_load, 0);
        check("rst_shift", sr_shift, 0);
        check("rst_clear", sr_clear, 0);
        in_valid = 1'b0;
        reset_n  = 1'b1;
        @(negedge clk);

        // Single product 3*5
        do_op(8'd3, 8'd5, 1'b1, rc);
        check("p1_run", rc, 8);
        out_hs("p1", 15, 1'b0);

        // Two-product frame; non-last op returns to IDLE after N+1 cycles
        do_op(8'd3, 8'd5, 1'b0, rc);
        check("f1_run", rc, 8);
        check("f1_ready", in_ready, 1);
        check("f1_nooutput", out_valid, 0);
        do_op(8'd7, 8'd9, 1'b1, rc);
        check("f2_run", rc, 8);
        out_hs("frame", 78, 1'b0);

        // Overflow frame then clean frame
        do_op(8'd255, 8'd255, 1'b0, rc);
        do_op(8'd255, 8'd255, 1'b1, rc);
        out_hs("ovf", 64514, 1'b1);
        do_op(8'd1, 8'd1, 1'b1, rc);
        out_hs("post_ovf", 1, 1'b0);

        // Hold OUT for 5 cycles with a competing input offered
        do_op(8'd3, 8'd5, 1'b1, rc);
        in_valid = 1'b1; in_a = 8'd7; in_b = 8'd7; in_last = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            check("hold_valid", out_valid, 1);
            check("hold_acc", out_acc, 15);
            check("hold_ready", in_ready, 0);
            check("hold_load", sr_load, 0);
            @(negedge clk);
        end
        in_valid = 1'b0;
        out_hs("hold", 15, 1'b0);

        // Zero / one multiplier RUN length
        do_op(8'd9, 8'd0, 1'b1, rc);
        check("b0_run", rc, RC_B0);
        out_hs("b0", 0, 1'b0);
        do_op(8'd9, 8'd1, 1'b1, rc);
        check("b1_run", rc, RC_B1);
        out_hs("b1", 9, 1'b0);

        // Reset mid-RUN discards the partial result
        in_a = 8'd3; in_b = 8'd5; in_last = 1'b1; in_valid = 1'b1;
        @(posedge clk); @(negedge clk);
        in_valid = 1'b0;
        repeat (4) @(negedge clk);
        check("midrun_busy", busy, 1);
        reset_n = 1'b0;
        #1;
        check("midrst_busy", busy, 0);
        check("midrst_ready", in_ready, 1);
        check("midrst_shift", sr_shift, 0);
        check("midrst_acc", out_acc, 0);
        $display("reset mid-RUN busy=%0d acc=%0d", busy, out_acc);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        do_op(8'd2, 8'd2, 1'b1, rc);
        check("postrst_run", rc, 8);
        out_hs("postrst", 4, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
